// File: rtl/bf16_add_arbiter.sv
// Round-robin front end that time-shares one pipelined BF16 adder among NUM_REQ
// requesters; a tag pipeline matched to the adder latency routes each sum back.

module bf16_add_arbiter_lane #(
  parameter int IDX_W = 2,
  parameter int LANE  = 0
) (
  input  logic             tag_vld,
  input  logic [IDX_W-1:0] tag_idx,
  output logic             rsp_valid
);
  assign rsp_valid = tag_vld && (tag_idx == IDX_W'(LANE));
endmodule

module bf16_add_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_TYPE   = 16,
  parameter int ADD_LATENCY = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_TYPE-1:0] req_A,
  input  logic [NUM_REQ*DATA_TYPE-1:0] req_B,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [DATA_TYPE-1:0]         add_A,
  output logic [DATA_TYPE-1:0]         add_B,
  input  logic [DATA_TYPE-1:0]         add_O,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [DATA_TYPE-1:0]         rsp_O,
  output logic                         busy,
  output logic [31:0]                  issue_count
);
  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int CW     = IDX_W + 1;
  localparam int STAGES = ADD_LATENCY;

  logic [NUM_REQ-1:0][DATA_TYPE-1:0] a_arr, b_arr;
  assign a_arr = req_A;
  assign b_arr = req_B;

  logic [IDX_W-1:0]             rr_ptr, gnt_idx, nxt_ptr;
  logic [CW-1:0]                cand;
  logic                         gnt_any;
  logic [STAGES:0]              vld_pipe;
  logic [STAGES:0][IDX_W-1:0]   idx_pipe;

  // Search from rr_ptr upward with wrap; first valid requester wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + CW'(k);
      if (cand >= CW'(NUM_REQ)) cand = cand - CW'(NUM_REQ);
      if (!gnt_any && en && !rst && req_valid[cand[IDX_W-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (gnt_any) req_ready[gnt_idx] = 1'b1;
  end

  assign nxt_ptr = (gnt_idx == IDX_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;

  // A grant is only ever given to a valid requester, so gnt_any is the transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr      <= '0;
      add_A       <= '0;
      add_B       <= '0;
      issue_count <= '0;
      vld_pipe    <= '0;
      idx_pipe    <= '0;
    end else begin
      if (gnt_any) begin
        rr_ptr      <= nxt_ptr;
        add_A       <= a_arr[gnt_idx];
        add_B       <= b_arr[gnt_idx];
        issue_count <= issue_count + 32'd1;
      end else begin
        add_A <= '0;
        add_B <= '0;
      end
      vld_pipe[0] <= gnt_any;
      idx_pipe[0] <= gnt_idx;
      for (int s = 1; s <= STAGES; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        idx_pipe[s] <= idx_pipe[s-1];
      end
    end
  end

  // The last tag stage lines up with the cycle add_O holds that operation's sum.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    bf16_add_arbiter_lane #(.IDX_W(IDX_W), .LANE(i)) u_lane (
      .tag_vld   (vld_pipe[STAGES]),
      .tag_idx   (idx_pipe[STAGES]),
      .rsp_valid (rsp_valid[i])
    );
  end

  assign rsp_O = add_O;
  assign busy  = |vld_pipe;
endmodule

// File: tb/tb_bf16_add_arbiter.sv
// Directed bench: a 2-cycle adder build and a combinational-adder build run side
// by side on the same requester stimulus.
module tb_bf16_add_arbiter;
  localparam int N = 4, DW = 16;

  logic clk = 1'b0, rst, en;
  logic [N-1:0] req_valid;
  logic [N-1:0][DW-1:0] a_arr, b_arr;
  logic [N*DW-1:0] req_A, req_B;
  assign req_A = a_arr;
  assign req_B = b_arr;

  logic [N-1:0]  req_ready, rsp_valid, req_ready0, rsp_valid0;
  logic [DW-1:0] add_A, add_B, add_O, rsp_O, add_A0, add_B0, add_O0, rsp_O0;
  logic          busy, busy0;
  logic [31:0]   issue_count, issue_count0;
  logic [DW-1:0] p1, p2;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  bf16_add_arbiter #(.NUM_REQ(N), .DATA_TYPE(DW), .ADD_LATENCY(2)) dut (
    .clk(clk), .rst(rst), .en(en), .req_valid(req_valid), .req_A(req_A), .req_B(req_B),
    .req_ready(req_ready), .add_A(add_A), .add_B(add_B), .add_O(add_O),
    .rsp_valid(rsp_valid), .rsp_O(rsp_O), .busy(busy), .issue_count(issue_count));

  bf16_add_arbiter #(.NUM_REQ(N), .DATA_TYPE(DW), .ADD_LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .req_valid(req_valid), .req_A(req_A), .req_B(req_B),
    .req_ready(req_ready0), .add_A(add_A0), .add_B(add_B0), .add_O(add_O0),
    .rsp_valid(rsp_valid0), .rsp_O(rsp_O0), .busy(busy0), .issue_count(issue_count0));

  // BF16 add for normal-range operands, via double precision.
  function automatic real bf2r(input logic [15:0] b);
    logic [63:0] d;
    if (b[14:0] == 15'd0) return 0.0;
    d = {b[15], 11'(b[14:7]) + 11'd896, b[6:0], 45'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [15:0] r2bf(input real r);
    logic [63:0] d;
    logic [15:0] o;
    if (r == 0.0) return 16'h0000;
    d = $realtobits(r);
    o = {d[63], 8'(d[62:52] - 11'd896), d[51:45]};
    if (d[44] && ((|d[43:0]) || d[45])) o = o + 16'd1;
    return o;
  endfunction

  function automatic logic [15:0] bf_add(input logic [15:0] a, input logic [15:0] b);
    return r2bf(bf2r(a) + bf2r(b));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      p1 <= '0;
      p2 <= '0;
    end else begin
      p1 <= bf_add(add_A, add_B);
      p2 <= p1;
    end
  end
  assign add_O = p2;
  always_comb add_O0 = bf_add(add_A0, add_B0);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    #4;
    rst = 1'b0;
    tick();
  endtask

  typedef struct {
    logic [15:0] a, b;
    logic [3:0]  gnt;
    logic [15:0] sum;
  } vec_t;

  vec_t        tv[4];
  logic [15:0] bs[8], sums[8];
  logic [3:0]  pre_gnt[3];
  logic [15:0] pre_sum[3];

  initial begin
    tv[0] = '{16'h4040, 16'h3F80, 4'b0001, 16'h4080};
    tv[1] = '{16'h4100, 16'h449B, 4'b0010, 16'h449C};
    tv[2] = '{16'h4480, 16'h4600, 4'b0100, 16'h4610};
    tv[3] = '{16'h3FA0, 16'h4020, 4'b1000, 16'h4070};
    bs    = '{16'h3F80, 16'h4000, 16'h4040, 16'h4080, 16'h40A0, 16'h40C0, 16'h40E0, 16'h4100};
    sums  = '{16'h4000, 16'h4040, 16'h4080, 16'h40A0, 16'h40C0, 16'h40E0, 16'h4100, 16'h4110};
    pre_gnt = '{4'b0010, 4'b1000, 4'b0001};
    pre_sum = '{16'h449C, 16'h4070, 16'h4080};

    // Reset state, with requests pending to show req_ready is held low.
    rst = 1'b1; en = 1'b1; req_valid = 4'hF; a_arr = '0; b_arr = '0;
    #12;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_addA", 32'(add_A), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_rspv", 32'(rsp_valid), 32'h0);
    chk("rst_count", issue_count, 32'h0);
    req_valid = '0;
    #10;
    rst = 1'b0;
    tick();

    // 1: single op from requester 0.
    req_valid = 4'b0001; a_arr[0] = 16'h4040; b_arr[0] = 16'h3F80;
    #1;
    chk("t1_gnt", 32'(req_ready), 32'h1);
    chk("t1_gnt0", 32'(req_ready0), 32'h1);
    tick();
    req_valid = '0;
    #1;
    chk("t1_addA", 32'(add_A), 32'h4040);
    chk("t1_addB", 32'(add_B), 32'h3F80);
    chk("t1_busy", 32'(busy), 32'h1);
    chk("t1_rspv_e1", 32'(rsp_valid), 32'h0);
    chk("t6_rspv0", 32'(rsp_valid0), 32'h1);
    chk("t6_rspO0", 32'(rsp_O0), 32'h4080);
    tick(); #1;
    chk("t1_rspv_e2", 32'(rsp_valid), 32'h0);
    chk("t6_rspv0_e2", 32'(rsp_valid0), 32'h0);
    tick(); #1;
    chk("t1_rspv", 32'(rsp_valid), 32'h1);
    chk("t1_rspO", 32'(rsp_O), 32'h4080);
    tick(); #1;
    chk("t1_busy_lo", 32'(busy), 32'h0);
    chk("t1_rspv_lo", 32'(rsp_valid), 32'h0);
    chk("t1_count", issue_count, 32'h1);

    // 2: all four requesters contend from a fresh reset.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      a_arr[k] = tv[k].a;
      b_arr[k] = tv[k].b;
    end
    for (int c = 0; c < 8; c++) begin
      req_valid = 4'(4'hF & ~((1 << c) - 1));
      #1;
      if (c < 4) chk("t2_gnt", 32'(req_ready), 32'(tv[c].gnt));
      if (c >= 3 && c < 7) begin
        chk("t2_rspv", 32'(rsp_valid), 32'(tv[c-3].gnt));
        chk("t2_rspO", 32'(rsp_O), 32'(tv[c-3].sum));
      end else chk("t2_rspv_idle", 32'(rsp_valid), 32'h0);
      if (c >= 1 && c < 5) begin
        chk("t6_rspv0", 32'(rsp_valid0), 32'(tv[c-1].gnt));
        chk("t6_rspO0", 32'(rsp_O0), 32'(tv[c-1].sum));
      end
      tick();
    end
    chk("t2_count", issue_count, 32'd4);

    // 3: rotate pointer past requester 1, then 3 beats 0; then 1 streams alone.
    req_valid = 4'b0010; #1; chk("t3_gnt1", 32'(req_ready), 32'b0010); tick();
    req_valid = 4'b1001; #1; chk("t3_gnt3", 32'(req_ready), 32'b1000); tick();
    req_valid = 4'b0001; #1; chk("t3_gnt0", 32'(req_ready), 32'b0001); tick();
    a_arr[1] = 16'h3F80;
    for (int c = 0; c < 11; c++) begin
      if (c < 8) begin
        req_valid = 4'b0010;
        b_arr[1] = bs[c];
      end else req_valid = '0;
      #1;
      if (c < 8) chk("t3_b2b_gnt", 32'(req_ready), 32'b0010);
      if (c < 3) begin
        chk("t3_pre_rspv", 32'(rsp_valid), 32'(pre_gnt[c]));
        chk("t3_pre_rspO", 32'(rsp_O), 32'(pre_sum[c]));
      end else begin
        chk("t3_b2b_rspv", 32'(rsp_valid), 32'b0010);
        chk("t3_b2b_rspO", 32'(rsp_O), 32'(sums[c-3]));
      end
      tick();
    end
    chk("t3_count", issue_count, 32'd15);

    // 4: en low blocks grants; then en drops right after two transfers.
    for (int k = 0; k < 4; k++) begin
      a_arr[k] = tv[k].a;
      b_arr[k] = tv[k].b;
    end
    en = 1'b0; req_valid = 4'hF;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("t4_off_gnt", 32'(req_ready), 32'h0);
      chk("t4_off_addA", 32'(add_A), 32'h0);
      chk("t4_off_addB", 32'(add_B), 32'h0);
      tick();
    end
    en = 1'b1;
    #1; chk("t4_gnt2", 32'(req_ready), 32'b0100); tick();
    #1; chk("t4_gnt3", 32'(req_ready), 32'b1000); tick();
    en = 1'b0;
    for (int d = 2; d < 6; d++) begin
      #1;
      chk("t4_drain_gnt", 32'(req_ready), 32'h0);
      if (d == 3) begin
        chk("t4_rspv2", 32'(rsp_valid), 32'b0100);
        chk("t4_rspO2", 32'(rsp_O), 32'h4610);
      end else if (d == 4) begin
        chk("t4_rspv3", 32'(rsp_valid), 32'b1000);
        chk("t4_rspO3", 32'(rsp_O), 32'h4070);
      end else chk("t4_rspv_idle", 32'(rsp_valid), 32'h0);
      tick();
    end
    chk("t4_count", issue_count, 32'd17);

    // 5: asynchronous reset mid-cycle with two operations in flight.
    en = 1'b1;
    req_valid = 4'b0011; #1; chk("t5_gnt0", 32'(req_ready), 32'b0001); tick();
    req_valid = 4'b0010; #1; chk("t5_gnt1", 32'(req_ready), 32'b0010); tick();
    req_valid = 4'hF;
    #2;
    rst = 1'b1;
    #1;
    chk("t5_busy", 32'(busy), 32'h0);
    chk("t5_addA", 32'(add_A), 32'h0);
    chk("t5_rspv", 32'(rsp_valid), 32'h0);
    chk("t5_count", issue_count, 32'h0);
    chk("t5_ready", 32'(req_ready), 32'h0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    req_valid = '0;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("t5_post_rspv", 32'(rsp_valid), 32'h0);
      chk("t5_post_rspv0", 32'(rsp_valid0), 32'h0);
      chk("t5_post_busy", 32'(busy), 32'h0);
    end
    req_valid = 4'b1100;
    #1;
    chk("t5_first_gnt", 32'(req_ready), 32'b0100);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
